// File: rtl/nbit_scoreboard_register_file.sv
// rtl/nbit_scoreboard_register_file.sv - register file with per-register pending (scoreboard) bits
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data and a cleared hazard to the read ports.
module nbit_scoreboard_register_file #(
  parameter int REG_SELECT_WIDTH = 5,
  parameter int DATA_WIDTH       = 32
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [REG_SELECT_WIDTH-1:0] ReadSelect1,
  input  logic [REG_SELECT_WIDTH-1:0] ReadSelect2,
  output logic [DATA_WIDTH-1:0]       ReadData1,
  output logic [DATA_WIDTH-1:0]       ReadData2,
  output logic                        Hazard1,
  output logic                        Hazard2,
  input  logic                        IssueEnable,
  input  logic [REG_SELECT_WIDTH-1:0] IssueSelect,
  input  logic                        WriteEnable,
  input  logic [REG_SELECT_WIDTH-1:0] WriteSelect,
  input  logic [DATA_WIDTH-1:0]       WriteData,
  output logic [REG_SELECT_WIDTH:0]   PendingCount
);

  localparam int NREGS = 2 ** REG_SELECT_WIDTH;
  localparam int CW    = REG_SELECT_WIDTH + 1;

  logic [DATA_WIDTH-1:0] regs_q [NREGS];
  logic [NREGS-1:0]      pending_q, pending_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_ok, iss_ok, cnt_inc, cnt_dec;

  assign wr_ok  = WriteEnable && (WriteSelect != '0);
  assign iss_ok = IssueEnable && (IssueSelect != '0);

  // Issue is applied after write so a same-register issue leaves the bit set.
  always_comb begin
    pending_d = pending_q;
    if (wr_ok)  pending_d[WriteSelect] = 1'b0;
    if (iss_ok) pending_d[IssueSelect] = 1'b1;
  end

  assign cnt_inc = iss_ok && !pending_q[IssueSelect];
  assign cnt_dec = wr_ok && pending_q[WriteSelect] && !(iss_ok && (IssueSelect == WriteSelect));

  always_comb begin
    count_d = count_q;
    if (cnt_inc && !cnt_dec)      count_d = count_q + CW'(1);
    else if (cnt_dec && !cnt_inc) count_d = count_q - CW'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      if (wr_ok) regs_q[WriteSelect] <= WriteData;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign PendingCount = count_q;

  // pending_q[0] can never be set, so the hazard needs no register-zero guard.
  always_comb begin
    ReadData1 = (ReadSelect1 == '0) ? '0 : regs_q[ReadSelect1];
    ReadData2 = (ReadSelect2 == '0) ? '0 : regs_q[ReadSelect2];
    Hazard1   = pending_q[ReadSelect1];
    Hazard2   = pending_q[ReadSelect2];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (WriteSelect == ReadSelect1)) begin
      ReadData1 = WriteData;
      Hazard1   = 1'b0;
    end
    if (wr_ok && (WriteSelect == ReadSelect2)) begin
      ReadData2 = WriteData;
      Hazard2   = 1'b0;
    end
`else
`endif
  end

endmodule

// File: tb/tb_nbit_scoreboard_register_file.sv
// tb/tb_nbit_scoreboard_register_file.sv - directed self-checking bench for nbit_scoreboard_register_file
// Expectations follow REGFILE_BYPASS_EN when the bench is built with it defined.
module tb_nbit_scoreboard_register_file;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  ReadSelect1, ReadSelect2, IssueSelect, WriteSelect;
  logic [31:0] ReadData1, ReadData2, WriteData;
  logic        Hazard1, Hazard2, IssueEnable, WriteEnable;
  logic [5:0]  PendingCount;

  int checks = 0;
  int errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  nbit_scoreboard_register_file #(.REG_SELECT_WIDTH(5), .DATA_WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset),
    .ReadSelect1(ReadSelect1), .ReadSelect2(ReadSelect2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .Hazard1(Hazard1), .Hazard2(Hazard2),
    .IssueEnable(IssueEnable), .IssueSelect(IssueSelect),
    .WriteEnable(WriteEnable), .WriteSelect(WriteSelect), .WriteData(WriteData),
    .PendingCount(PendingCount)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    IssueEnable = 1'b0;
    WriteEnable = 1'b0;
  endtask

  task automatic test_reset();
    IssueEnable = 1'b1; IssueSelect = 5'd9;
    WriteEnable = 1'b1; WriteSelect = 5'd6; WriteData = 32'h11;
    tick();
    idle();
    ReadSelect1 = 5'd6; ReadSelect2 = 5'd9;
    #1;
    checks++; if (PendingCount !== 6'd1) begin errors++; $display("FAIL pre_reset_count got %0d exp 1", PendingCount); end
    checks++; if (ReadData1 !== 32'h11) begin errors++; $display("FAIL pre_reset_rd1 got %h exp 00000011", ReadData1); end
    checks++; if (Hazard2 !== 1'b1) begin errors++; $display("FAIL pre_reset_hz2 got %b exp 1", Hazard2); end
    #1 Reset = 1'b1;
    #1;
    checks++; if (ReadData1 !== 32'h0 || ReadData2 !== 32'h0) begin errors++; $display("FAIL async_reset_data got %h/%h exp 0/0", ReadData1, ReadData2); end
    checks++; if (Hazard1 !== 1'b0 || Hazard2 !== 1'b0) begin errors++; $display("FAIL async_reset_hazard got %b/%b exp 0/0", Hazard1, Hazard2); end
    checks++; if (PendingCount !== 6'd0) begin errors++; $display("FAIL async_reset_count got %0d exp 0", PendingCount); end
    tick();
    Reset = 1'b0;
    WriteEnable = 1'b1; WriteSelect = 5'd5; WriteData = 32'hDEADBEEF;
    ReadSelect1 = 5'd5;
    #1;
    checks++; if (ReadData1 !== (BYP ? 32'hDEADBEEF : 32'h0)) begin errors++; $display("FAIL write_cycle_rd1 got %h exp %h", ReadData1, BYP ? 32'hDEADBEEF : 32'h0); end
    tick();
    idle();
    #1;
    checks++; if (ReadData1 !== 32'hDEADBEEF) begin errors++; $display("FAIL write_r5 got %h exp deadbeef", ReadData1); end
  endtask

  task automatic test_reg_zero();
    WriteEnable = 1'b1; WriteSelect = 5'd0; WriteData = 32'h12345678;
    IssueEnable = 1'b1; IssueSelect = 5'd0;
    ReadSelect1 = 5'd0;
    #1;
    checks++; if (ReadData1 !== 32'h0 || Hazard1 !== 1'b0) begin errors++; $display("FAIL r0_same_cycle got %h/%b exp 0/0", ReadData1, Hazard1); end
    tick();
    idle();
    #1;
    checks++; if (ReadData1 !== 32'h0) begin errors++; $display("FAIL r0_data got %h exp 0", ReadData1); end
    checks++; if (Hazard1 !== 1'b0) begin errors++; $display("FAIL r0_hazard got %b exp 0", Hazard1); end
    checks++; if (PendingCount !== 6'd0) begin errors++; $display("FAIL r0_count got %0d exp 0", PendingCount); end
  endtask

  task automatic test_scoreboard();
    IssueEnable = 1'b1; IssueSelect = 5'd3;
    ReadSelect1 = 5'd3;
    #1;
    checks++; if (Hazard1 !== 1'b0) begin errors++; $display("FAIL issue_not_early got %b exp 0", Hazard1); end
    tick();
    idle();
    #1;
    checks++; if (Hazard1 !== 1'b1) begin errors++; $display("FAIL issue_r3_hazard got %b exp 1", Hazard1); end
    checks++; if (PendingCount !== 6'd1) begin errors++; $display("FAIL issue_r3_count got %0d exp 1", PendingCount); end
    WriteEnable = 1'b1; WriteSelect = 5'd3; WriteData = 32'hA5;
    #1;
    checks++; if (Hazard1 !== !BYP) begin errors++; $display("FAIL wb_cycle_hazard got %b exp %b", Hazard1, !BYP); end
    checks++; if (ReadData1 !== (BYP ? 32'hA5 : 32'h0)) begin errors++; $display("FAIL wb_cycle_data got %h exp %h", ReadData1, BYP ? 32'hA5 : 32'h0); end
    tick();
    idle();
    #1;
    checks++; if (Hazard1 !== 1'b0 || ReadData1 !== 32'hA5) begin errors++; $display("FAIL wb_after got %b/%h exp 0/a5", Hazard1, ReadData1); end
    checks++; if (PendingCount !== 6'd0) begin errors++; $display("FAIL wb_after_count got %0d exp 0", PendingCount); end
  endtask

  task automatic test_simultaneous();
    IssueEnable = 1'b1; IssueSelect = 5'd7;
    tick();
    IssueEnable = 1'b1; IssueSelect = 5'd7;
    WriteEnable = 1'b1; WriteSelect = 5'd7; WriteData = 32'h55;
    tick();
    idle();
    ReadSelect1 = 5'd7; ReadSelect2 = 5'd8;
    #1;
    checks++; if (ReadData1 !== 32'h55) begin errors++; $display("FAIL same_reg_data got %h exp 55", ReadData1); end
    checks++; if (Hazard1 !== 1'b1) begin errors++; $display("FAIL same_reg_hazard got %b exp 1", Hazard1); end
    checks++; if (PendingCount !== 6'd1) begin errors++; $display("FAIL same_reg_count got %0d exp 1", PendingCount); end
    IssueEnable = 1'b1; IssueSelect = 5'd8;
    WriteEnable = 1'b1; WriteSelect = 5'd7; WriteData = 32'h66;
    tick();
    idle();
    #1;
    checks++; if (PendingCount !== 6'd1) begin errors++; $display("FAIL swap_count got %0d exp 1", PendingCount); end
    checks++; if (Hazard1 !== 1'b0 || Hazard2 !== 1'b1) begin errors++; $display("FAIL swap_hazards got r7=%b r8=%b exp 0/1", Hazard1, Hazard2); end
    checks++; if (ReadData1 !== 32'h66) begin errors++; $display("FAIL swap_r7_data got %h exp 66", ReadData1); end
    WriteEnable = 1'b1; WriteSelect = 5'd8; WriteData = 32'h88;
    tick();
    idle();
    #1;
    checks++; if (PendingCount !== 6'd0) begin errors++; $display("FAIL clear_r8_count got %0d exp 0", PendingCount); end
  endtask

  task automatic test_fill();
    for (int i = 1; i < 32; i++) begin
      IssueEnable = 1'b1; IssueSelect = 5'(i);
      tick();
    end
    idle();
    ReadSelect1 = 5'd31; ReadSelect2 = 5'd1;
    #1;
    checks++; if (PendingCount !== 6'd31) begin errors++; $display("FAIL fill_count got %0d exp 31", PendingCount); end
    checks++; if (Hazard1 !== 1'b1 || Hazard2 !== 1'b1) begin errors++; $display("FAIL fill_hazards got %b/%b exp 1/1", Hazard1, Hazard2); end
    IssueEnable = 1'b1; IssueSelect = 5'd5;
    tick();
    idle();
    #1;
    checks++; if (PendingCount !== 6'd31) begin errors++; $display("FAIL reissue_full_count got %0d exp 31", PendingCount); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      IssueEnable = 1'b1; IssueSelect = 5'(i);
      tick();
    end
    IssueSelect = 5'd11;
    ReadSelect1 = 5'd10; ReadSelect2 = 5'd1;
    #1;
    checks++; if (PendingCount !== 6'd10) begin errors++; $display("FAIL partial_count got %0d exp 10", PendingCount); end
    Reset = 1'b1;
    #1;
    checks++; if (PendingCount !== 6'd0) begin errors++; $display("FAIL mid_reset_count got %0d exp 0", PendingCount); end
    checks++; if (Hazard1 !== 1'b0 || Hazard2 !== 1'b0) begin errors++; $display("FAIL mid_reset_hazards got %b/%b exp 0/0", Hazard1, Hazard2); end
    tick();
    idle();
    Reset = 1'b0;
    #1;
    checks++; if (PendingCount !== 6'd0) begin errors++; $display("FAIL reset_drop_issue got %0d exp 0", PendingCount); end
    IssueEnable = 1'b1; IssueSelect = 5'd2;
    tick();
    #1;
    checks++; if (PendingCount !== 6'd1) begin errors++; $display("FAIL reissue_r2_count got %0d exp 1", PendingCount); end
    tick();
    idle();
    WriteEnable = 1'b1; WriteSelect = 5'd4; WriteData = 32'h44;
    tick();
    idle();
    ReadSelect1 = 5'd2; ReadSelect2 = 5'd4;
    #1;
    checks++; if (PendingCount !== 6'd1) begin errors++; $display("FAIL dup_and_nonpending_count got %0d exp 1", PendingCount); end
    checks++; if (Hazard1 !== 1'b1 || ReadData2 !== 32'h44) begin errors++; $display("FAIL r2_r4_state got %b/%h exp 1/44", Hazard1, ReadData2); end
  endtask

  task automatic test_dual_read();
    IssueEnable = 1'b1; IssueSelect = 5'd4;
    tick();
    idle();
    ReadSelect1 = 5'd4; ReadSelect2 = 5'd4;
    WriteEnable = 1'b1; WriteSelect = 5'd4; WriteData = 32'h77;
    #1;
    checks++; if (ReadData1 !== (BYP ? 32'h77 : 32'h44) || ReadData2 !== (BYP ? 32'h77 : 32'h44)) begin errors++; $display("FAIL dual_wb_data got %h/%h exp %h", ReadData1, ReadData2, BYP ? 32'h77 : 32'h44); end
    checks++; if (Hazard1 !== !BYP || Hazard2 !== !BYP) begin errors++; $display("FAIL dual_wb_hazard got %b/%b exp %b", Hazard1, Hazard2, !BYP); end
    tick();
    idle();
    #1;
    checks++; if (ReadData1 !== 32'h77 || ReadData2 !== 32'h77) begin errors++; $display("FAIL dual_after_data got %h/%h exp 77/77", ReadData1, ReadData2); end
    checks++; if (Hazard1 !== 1'b0 || Hazard2 !== 1'b0 || PendingCount !== 6'd1) begin errors++; $display("FAIL dual_after_state got %b/%b cnt %0d exp 0/0 cnt 1", Hazard1, Hazard2, PendingCount); end
  endtask

  initial begin
    Reset = 1'b1;
    ReadSelect1 = '0; ReadSelect2 = '0;
    IssueEnable = 1'b0; IssueSelect = '0;
    WriteEnable = 1'b0; WriteSelect = '0; WriteData = '0;
    tick();
    tick();
    Reset = 1'b0;
    test_reset();
    test_reg_zero();
    test_scoreboard();
    test_simultaneous();
    test_fill();
    test_dual_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nbit_scoreboard_register_file.md
# nbit_scoreboard_register_file

Parametrised register file for the pipelined datapath: two combinational read ports, one writeback port, and a per-register pending (scoreboard) bit so decode can detect RAW hazards. Register 0 is hardwired to zero. An optional write-through bypass forwards same-cycle writeback data to the read ports. It sits between decode (read and issue) and writeback.

## Interface
- REG_SELECT_WIDTH, 5, select width; the file holds 2**REG_SELECT_WIDTH registers
- DATA_WIDTH, 32, register width in bits

- Clk  input  1  clock; all state updates on posedge
- Reset  input  1  asynchronous, active-high; clears all registers, pending bits and PendingCount
- ReadSelect1  input  REG_SELECT_WIDTH  read port 1 address
- ReadSelect2  input  REG_SELECT_WIDTH  read port 2 address
- ReadData1  output  DATA_WIDTH  read port 1 data (combinational)
- ReadData2  output  DATA_WIDTH  read port 2 data (combinational)
- Hazard1  output  1  operand 1 not yet valid (combinational)
- Hazard2  output  1  operand 2 not yet valid (combinational)
- IssueEnable  input  1  marks IssueSelect pending on posedge
- IssueSelect  input  REG_SELECT_WIDTH  destination register of the issuing instruction
- WriteEnable  input  1  writeback strobe
- WriteSelect  input  REG_SELECT_WIDTH  writeback destination
- WriteData  input  DATA_WIDTH  writeback data
- PendingCount  output  REG_SELECT_WIDTH+1  registered number of set pending bits

## Operation
- Storage: regs[0..2**REG_SELECT_WIDTH-1]. regs[0] always reads 0. Writes and issues to register 0 are ignored.
- Write (posedge, WriteEnable, WriteSelect≠0):
  - regs[WriteSelect] ← WriteData.
  - pending[WriteSelect] ← 0, unless an issue to the same register occurs in that cycle.
- Issue (posedge, IssueEnable, IssueSelect≠0): pending[IssueSelect] ← 1.
- Issue and write to the same register in the same cycle:
  - Data is written.
  - The pending bit ends at 1, because the new producer wins.
- Issue to a register that is already pending: the bit stays 1 and the count is unchanged. WAW ordering is the issuer's responsibility.
- Write to a register that is not pending: data is written and the count is unchanged.
- Read: ReadDataN = regs[ReadSelectN]; HazardN = pending[ReadSelectN]. Selecting register 0 always gives data 0 and hazard 0.
- PendingCount is maintained incrementally as +1 per 0→1 transition and −1 per 1→0 transition, both in the same cycle. Net change per cycle is in {−1, 0, +1}. It always equals popcount(pending) and never exceeds 2**REG_SELECT_WIDTH−1.

## Timing
- Reset is asynchronous: outputs respond immediately without waiting for Clk. After reset:
  - ReadData1 = ReadData2 = 0.
  - Hazard1 = Hazard2 = 0.
  - PendingCount = 0.
- Reset asserted mid-operation discards any in-flight issue or write. The first state change after release occurs on the first posedge with Reset low.
- Write-to-read latency without bypass is 1 cycle: new data is visible after the posedge.
- Issue-to-hazard latency is 1 cycle: HazardN rises after the posedge that samples IssueEnable.
- PendingCount updates on the same posedge as the pending bits.
- Reads are purely combinational from the selects, stored state and (with bypass) the write port. There is no read-enable.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If WriteEnable is high, WriteSelect = ReadSelectN and ReadSelectN ≠ 0, then ReadDataN = WriteData and HazardN = 0 in the same cycle.
  - A read therefore sees a writeback with 0-cycle latency.
- REGFILE_BYPASS_EN undefined:
  - ReadDataN comes from storage only.
  - HazardN = pending[ReadSelectN] even during a matching writeback.
  - The value and the cleared hazard appear one cycle later.
- Sequential behaviour is identical in both builds.

## Test plan
- Reset with defaults: assert Reset between clock edges → ReadData1/2 = 0, Hazard1/2 = 0 and PendingCount = 0 immediately. Then write 0xDEADBEEF to r5 → ReadData1 = 0xDEADBEEF with ReadSelect1 = 5 on the next cycle.
- Register zero: write 0x12345678 to r0 and issue r0 → ReadData1 = 0, Hazard1 = 0 and PendingCount = 0.
- Scoreboard flow: issue r3 → Hazard1 = 1 and PendingCount = 1. Then write 0xA5 to r3 →
  - with REGFILE_BYPASS_EN: Hazard1 = 0 and ReadData1 = 0xA5 in the write cycle;
  - without it: both appear one cycle later.
  - In both builds PendingCount = 0 afterwards.
- Simultaneous issue and write to r7 (r7 pending, WriteData 0x55): r7 = 0x55, Hazard stays 1 and PendingCount is unchanged. Issue r8 while writing r7 in the same cycle → count unchanged, r8 pending, r7 clear.
- Fill and count: issue r1..r31 on consecutive cycles → PendingCount reaches 31. Assert Reset mid-sequence (after r10) → count = 0 and all hazards 0 asynchronously. Re-issue r2 → count = 1.
- Dual read: ReadSelect1 = ReadSelect2 = r4 during a writeback of 0x77 to r4 with bypass → both ports read 0x77 and both hazards are 0.
